// File: rtl/dvs_event_dispatcher.sv
// dvs_event_dispatcher: FIFO-buffered DVS events scheduled onto one valid/ready channel.
// Define DVS_DISPATCH_HEARTBEAT_EN to compile in the idle timer and heartbeat words.
module dvs_event_dispatcher #(
    parameter int FIFO_DEPTH        = 8,
    parameter int HEARTBEAT_US      = 1000,
    parameter int DVS_X_ADDR_BITS   = 9,
    parameter int DVS_Y_ADDR_BITS   = 9,
    parameter int TIMESTAMP_US_BITS = 16,
    localparam int W  = 2 + DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + TIMESTAMP_US_BITS,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DVS_X_ADDR_BITS-1:0]   event_x,
    input  logic [DVS_Y_ADDR_BITS-1:0]   event_y,
    input  logic [TIMESTAMP_US_BITS-1:0] event_timestamp,
    input  logic                         event_polarity,
    input  logic                         new_event,
    input  logic [TIMESTAMP_US_BITS-1:0] time_us,
    output logic [W-1:0]                 out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LW-1:0]                fifo_level,
    output logic [15:0]                  drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = W - 1;

`ifdef DVS_DISPATCH_HEARTBEAT_EN
    typedef enum logic [1:0] {IDLE, SEND_EVENT, SEND_HB} state_t;
`else
    typedef enum logic {IDLE, SEND_EVENT} state_t;
`endif

    state_t state, next_state;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, empty, push, pop, drop;

    assign full  = fifo_level == LW'(FIFO_DEPTH);
    assign empty = fifo_level == '0;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push  = new_event && (!full || pop);
    assign drop  = new_event && full && !pop;
    assign out_valid = state != IDLE;

`ifdef DVS_DISPATCH_HEARTBEAT_EN
    localparam int CW = $clog2(HEARTBEAT_US + 1);
    localparam logic [CW-1:0] HB = CW'(HEARTBEAT_US);
    logic [TIMESTAMP_US_BITS-1:0] time_q;
    logic [CW-1:0] idle_cnt;
    logic hb_pending, load_hb, tick, hb_set;

    assign tick   = time_us != time_q;
    assign hb_set = tick && idle_cnt == HB - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q     <= '0;
            idle_cnt   <= '0;
            hb_pending <= 1'b0;
        end else begin
            time_q <= time_us;
            if (out_valid && out_ready) begin
                idle_cnt   <= '0;
                hb_pending <= 1'b0;
            end else begin
                if (tick && idle_cnt != HB)
                    idle_cnt <= idle_cnt + 1'b1;
                hb_pending <= (hb_pending || hb_set) && !pop;
            end
        end
    end
`else
    localparam int unused_hb = HEARTBEAT_US;
    logic unused_time;
    assign unused_time = ^time_us;
`endif

    always_comb begin
        next_state = state;
        pop        = 1'b0;
`ifdef DVS_DISPATCH_HEARTBEAT_EN
        load_hb    = 1'b0;
`endif
        if (state == IDLE) begin
            if (!empty) begin
                pop        = 1'b1;
                next_state = SEND_EVENT;
            end
`ifdef DVS_DISPATCH_HEARTBEAT_EN
            else if (hb_pending) begin
                load_hb    = 1'b1;
                next_state = SEND_HB;
            end
`endif
        end else if (out_ready) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_data   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_count <= '0;
        end else begin
            state <= next_state;
            if (pop)
                out_data <= {1'b0, mem[rd_ptr]};
`ifdef DVS_DISPATCH_HEARTBEAT_EN
            else if (load_hb)
                out_data <= {2'b10, {(DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS){1'b0}}, time_us};
`endif
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {event_polarity, event_x, event_y, event_timestamp};
    end
endmodule

// File: tb/tb_dvs_event_dispatcher.sv
// tb_dvs_event_dispatcher: directed scoreboard bench for dvs_event_dispatcher.
// Heartbeat scenarios run only when DVS_DISPATCH_HEARTBEAT_EN is defined.
module tb_dvs_event_dispatcher;
    localparam int W = 36;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8:0]    event_x;
    logic [8:0]    event_y;
    logic [15:0]   event_timestamp;
    logic          event_polarity;
    logic          new_event;
    logic [15:0]   time_us;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fifo_level;
    logic [15:0]   drop_count;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] sb[$];
    logic pv = 1'b0, pr = 1'b0;
    logic [W-1:0] pd = '0;

    dvs_event_dispatcher #(.FIFO_DEPTH(8), .HEARTBEAT_US(4), .DVS_X_ADDR_BITS(9),
                           .DVS_Y_ADDR_BITS(9), .TIMESTAMP_US_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .event_x(event_x), .event_y(event_y),
        .event_timestamp(event_timestamp), .event_polarity(event_polarity),
        .new_event(new_event), .time_us(time_us), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev_word(logic p, logic [8:0] x, logic [8:0] y, logic [15:0] ts);
        return {1'b0, p, x, y, ts};
    endfunction

    function automatic logic [W-1:0] hb_word(logic [15:0] ts);
        return {2'b10, 18'b0, ts};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(logic p, logic [8:0] x, logic [8:0] y, logic [15:0] ts, logic expect_out);
        event_polarity  = p;
        event_x         = x;
        event_y         = y;
        event_timestamp = ts;
        new_event       = 1'b1;
        if (expect_out) sb.push_back(ev_word(p, x, y, ts));
        cyc(1);
        new_event = 1'b0;
    endtask

    task automatic drain(string tag, int budget);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks hold stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv && !pr) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(pd));
            end
            if (out_valid && out_ready) begin
                vectors++;
                assert (sb.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_word: observed %0h expected none", out_data);
                end
                if (sb.size() != 0) check("out_word", 64'(out_data), 64'(sb.pop_front()));
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end else begin
            pv = 1'b0;
        end
    end

    initial begin
        #300000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; new_event = 1'b0; out_ready = 1'b0; time_us = '0;
        event_x = '0; event_y = '0; event_timestamp = '0; event_polarity = 1'b0;
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(2);

        // single event, exact latency and one-cycle valid
        out_ready = 1'b1;
        strobe(1'b1, 9'd5, 9'd3, 16'd100, 1'b1);
        @(negedge clk);
        check("lat_edge1_valid", 64'(out_valid), 64'd0);
        check("lat_edge1_level", 64'(fifo_level), 64'd1);
        @(negedge clk);
        check("lat_edge2_valid", 64'(out_valid), 64'd1);
        check("lat_edge2_data", 64'(out_data), 64'(ev_word(1'b1, 9'd5, 9'd3, 16'd100)));
        @(negedge clk);
        check("one_cycle_valid", 64'(out_valid), 64'd0);
        cyc(2);

        // overflow with output stalled, then simultaneous push/pop while full
        out_ready = 1'b0;
        strobe(1'b0, 9'd1, 9'd1, 16'd1000, 1'b1);
        cyc(3);
        check("stall_loaded", 64'(out_valid), 64'd1);
        for (int i = 1; i <= 10; i++) begin
            event_polarity  = i[0];
            event_x         = 9'(10 + i);
            event_y         = 9'(20 + i);
            event_timestamp = 16'(2000 + i);
            new_event       = 1'b1;
            if (i <= 8) sb.push_back(ev_word(i[0], 9'(10 + i), 9'(20 + i), 16'(2000 + i)));
            cyc(1);
        end
        new_event = 1'b0;
        @(negedge clk);
        check("full_level", 64'(fifo_level), 64'd8);
        check("full_drop", 64'(drop_count), 64'd2);
        cyc(20);
        check("stall_data", 64'(out_data), 64'(ev_word(1'b0, 9'd1, 9'd1, 16'd1000)));
        out_ready = 1'b1;
        cyc(1);
        strobe(1'b1, 9'd99, 9'd77, 16'd3000, 1'b1);
        @(negedge clk);
        check("pushpop_level", 64'(fifo_level), 64'd8);
        check("pushpop_drop", 64'(drop_count), 64'd2);
        drain("drain_burst", 200);
        check("drain_level", 64'(fifo_level), 64'd0);

        // reset while a word is loaded and three are queued
        out_ready = 1'b0;
        cyc(1);
        for (int i = 0; i < 4; i++) strobe(1'b1, 9'(40 + i), 9'(50 + i), 16'(4000 + i), 1'b1);
        cyc(3);
        check("pre_rst_level", 64'(fifo_level), 64'd3);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_drop", 64'(drop_count), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc(20);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_level", 64'(fifo_level), 64'd0);

`ifdef DVS_DISPATCH_HEARTBEAT_EN
        // heartbeat after four idle ticks, then again four ticks after acceptance
        sb.push_back(hb_word(16'd4));
        sb.push_back(hb_word(16'd8));
        for (int t = 1; t <= 8; t++) begin
            time_us = 16'(t);
            if (t % 4 == 0) begin
                @(negedge clk);
                check("hb_wait1", 64'(out_valid), 64'd0);
                @(negedge clk);
                check("hb_wait2", 64'(out_valid), 64'd0);
                @(negedge clk);
                check("hb_valid", 64'(out_valid), 64'd1);
                #1;
            end
            cyc(50);
        end
        check("hb_pair_seen", 64'(sb.size()), 64'd0);
        // event arriving as hb_pending sets suppresses the heartbeat
        for (int t = 9; t <= 11; t++) begin
            time_us = 16'(t);
            cyc(50);
        end
        time_us = 16'd12;
        strobe(1'b0, 9'd7, 9'd8, 16'd12, 1'b1);
        cyc(300);
        check("collide_only_event", 64'(sb.size()), 64'd0);
        // all-ones to zero still counts as a tick
        sb.push_back(hb_word(16'd1));
        time_us = 16'hFFFE; cyc(50);
        time_us = 16'hFFFF; cyc(50);
        time_us = 16'h0000; cyc(50);
        time_us = 16'h0001; cyc(50);
        check("wrap_hb", 64'(sb.size()), 64'd0);
`else
        // without heartbeat support, time advancing alone never produces a word
        for (int t = 1; t <= 8; t++) begin
            time_us = 16'(t);
            cyc(50);
        end
        check("no_hb_valid", 64'(out_valid), 64'd0);
        strobe(1'b1, 9'd2, 9'd4, 16'd6, 1'b1);
`endif
        drain("final_drain", 200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
